// File: rtl/sw_debounce_pkg.sv
// Shared types and default constants for the switch debouncer.
package sw_debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } db_state_t;

    localparam int DB_SYNC_STAGES_DEF = 2;
    localparam int DB_CYCLES_DEF      = 1_000_000;

endpackage

// File: rtl/debounce_channel.sv
// One debounced channel: synchroniser, stability FSM/counter and registered
// level/edge outputs.
module debounce_channel
    import sw_debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = DB_SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic clean_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] shift_q, shift_d;
    logic                   sync_q;
    db_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   clean_q, clean_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // Synchroniser: plain shift register, no logic between stages.
    assign shift_d = {shift_q[SYNC_STAGES-2:0], raw_in};
    assign sync_q  = shift_q[SYNC_STAGES-1];

    // Stability qualification; counter is cleared on every abort and accept.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LO: begin
                if (sync_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = STABLE_HI;
                        cnt_d   = '0;
                        clean_d = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = WAIT_HI;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            WAIT_HI: begin
                if (!sync_q) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    clean_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!sync_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                        clean_d = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = WAIT_LO;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            WAIT_LO: begin
                if (sync_q) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    clean_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean_out  = clean_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: rtl/switch_debouncer.sv
// Multi-channel switch debouncer: independent per-bit channels plus a
// combined change indicator.
module switch_debouncer
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH           = 3,
    parameter int SYNC_STAGES     = DB_SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DB_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
        $error("switch_debouncer: DEBOUNCE_CYCLES must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("switch_debouncer: SYNC_STAGES must be >= 2");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .raw_in    (raw_in[i]),
            .clean_out (clean_out[i]),
            .rise_pulse(rise_pulse[i]),
            .fall_pulse(fall_pulse[i])
        );
    end

    // Pulses are already registered, so this OR adds no path from raw_in.
    assign any_change = |{rise_pulse, fall_pulse};

endmodule

// File: tb/tb_switch_debouncer.sv
// Randomised and directed bench for switch_debouncer against a run-length
// reference model of the debounce rule.
module tb_switch_debouncer;

    localparam int W    = 3;
    localparam int SYNC = 2;
    localparam int DB   = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] raw_in;
    logic [W-1:0] clean_out, rise_pulse, fall_pulse;
    logic         any_change;

    int n_checks = 0;
    int n_pass   = 0;

    switch_debouncer #(
        .WIDTH          (W),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .raw_in    (raw_in),
        .clean_out (clean_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .any_change(any_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the FSM sees raw_in delayed by SYNC edges; clean flips once the
    // seen level has disagreed with clean for DB consecutive edges.
    logic [W-1:0] pipe [SYNC];
    logic [W-1:0] m_clean = '0, m_rise = '0, m_fall = '0;
    logic [W-1:0] seen;
    int           run [W];

    initial begin
        for (int i = 0; i < SYNC; i++) pipe[i] = '0;
        for (int c = 0; c < W; c++) run[c] = 0;
    end

    always @(posedge clk) begin
        seen = pipe[SYNC-1];
        if (rst) begin
            for (int i = 0; i < SYNC; i++) pipe[i] = '0;
            for (int c = 0; c < W; c++) run[c] = 0;
            m_clean = '0;
            m_rise  = '0;
            m_fall  = '0;
        end else begin
            for (int i = SYNC - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = raw_in;
            m_rise  = '0;
            m_fall  = '0;
            for (int c = 0; c < W; c++) begin
                if (seen[c] != m_clean[c]) begin
                    run[c] = run[c] + 1;
                    if (run[c] == DB) begin
                        m_clean[c] = seen[c];
                        if (seen[c]) m_rise[c] = 1'b1;
                        else         m_fall[c] = 1'b1;
                        run[c] = 0;
                    end
                end else begin
                    run[c] = 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("m_clean", 32'(clean_out), 32'(m_clean));
            chk("m_rise",  32'(rise_pulse), 32'(m_rise));
            chk("m_fall",  32'(fall_pulse), 32'(m_fall));
            chk("m_any",   32'(any_change), 32'(|{m_rise, m_fall}));
        end
    endtask

    initial begin
        rst    = 1'b1;
        raw_in = '0;
        @(negedge clk);
        tick(3);
        chk("rst_clean", 32'(clean_out), 32'h0);
        chk("rst_any",   32'(any_change), 32'h0);
        rst = 1'b0;
        tick(2);

        // Clean press on channel 0
        raw_in = 3'b001;
        tick(5);
        chk("press_e5_clean", 32'(clean_out), 32'h0);
        tick();
        chk("press_e6_clean", 32'(clean_out), 32'h1);
        chk("press_e6_rise",  32'(rise_pulse), 32'h1);
        chk("press_e6_any",   32'(any_change), 32'h1);
        tick();
        chk("press_e7_rise",  32'(rise_pulse), 32'h0);
        chk("press_e7_any",   32'(any_change), 32'h0);

        // Bounce on channel 1, then a real press
        raw_in = 3'b011; tick(2);
        raw_in = 3'b001; tick(2);
        raw_in = 3'b011; tick(2);
        raw_in = 3'b001; tick(8);
        chk("bounce_clean", 32'(clean_out), 32'h1);
        raw_in = 3'b011;
        tick(6);
        chk("bounce_press_clean", 32'(clean_out), 32'h3);
        chk("bounce_press_rise",  32'(rise_pulse), 32'h2);

        // Release channel 0
        raw_in = 3'b010;
        tick(6);
        chk("release_clean", 32'(clean_out), 32'h2);
        chk("release_fall",  32'(fall_pulse), 32'h1);
        chk("release_rise",  32'(rise_pulse), 32'h0);
        raw_in = 3'b000;
        tick(10);

        // Simultaneous press
        raw_in = 3'b111;
        tick(6);
        chk("simul_rise", 32'(rise_pulse), 32'h7);
        chk("simul_any",  32'(any_change), 32'h1);
        tick();
        chk("simul_any_end", 32'(any_change), 32'h0);
        raw_in = 3'b000;
        tick(10);

        // Reset during WAIT_HI at cnt=2, level held through release
        raw_in = 3'b001;
        tick(4);
        rst = 1'b1; tick();
        chk("rst_mid_clean", 32'(clean_out), 32'h0);
        rst = 1'b0;
        tick(5);
        chk("rst_mid_e5", 32'(clean_out), 32'h0);
        tick();
        chk("rst_mid_e6_clean", 32'(clean_out), 32'h1);
        chk("rst_mid_e6_rise",  32'(rise_pulse), 32'h1);

        // Reset while a debounced level is high
        raw_in = 3'b101;
        tick(4);
        rst = 1'b1; tick();
        chk("rst_hi_clean", 32'(clean_out), 32'h0);
        rst = 1'b0;
        tick(6);
        chk("rst_hi_rise", 32'(rise_pulse), 32'h5);
        raw_in = 3'b000;
        tick(10);

        // Boundary: 3 cycles rejected, 4 cycles accepted
        raw_in = 3'b010; tick(3);
        raw_in = 3'b000; tick(8);
        chk("short3_clean", 32'(clean_out), 32'h0);
        raw_in = 3'b010; tick(4);
        raw_in = 3'b000; tick(2);
        chk("exact4_clean", 32'(clean_out), 32'h2);
        chk("exact4_rise",  32'(rise_pulse), 32'h2);
        tick(10);

        // Random bouncing with occasional reset
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < W; c++)
                if ($urandom_range(5) == 0) raw_in[c] = ~raw_in[c];
            rst = ($urandom_range(199) == 0);
            tick();
        end
        rst = 1'b0;
        tick(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Conditions raw board switch/button levels into clean, glitch-free logic levels for the downstream combinational logic (e.g. the three-input gate inputs). Each channel is synchronised into the `clk` domain, then qualified by a per-channel stability counter. Debounced levels and single-cycle edge pulses are presented to downstream logic. Sits directly behind the top-level switch pins, in front of all user logic.

## Interface
- `WIDTH`, 3: number of independent input channels.
- `SYNC_STAGES`, 2: synchroniser flop depth, ≥2.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles required to accept a new level; 10 ms at 100 MHz; must be ≥1.

Ports:
- `clk`  in  1  system clock; all state is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `raw_in`  in  WIDTH  asynchronous switch/button levels.
- `clean_out`  out  WIDTH  debounced level per channel.
- `rise_pulse`  out  WIDTH  one-cycle pulse when the matching `clean_out` bit goes 0→1.
- `fall_pulse`  out  WIDTH  one-cycle pulse when the matching `clean_out` bit goes 1→0.
- `any_change`  out  1  OR of all `rise_pulse` and `fall_pulse` bits.

## Operation
- Synchroniser: `SYNC_STAGES` flops per bit. The last stage is `sync_q`. No logic sits between the stages.
- Per-channel FSM, states `STABLE_LO`, `WAIT_HI`, `STABLE_HI`, `WAIT_LO`:
  - `STABLE_LO`: if `sync_q`=1, go to `WAIT_HI` with `cnt`=1. If `DEBOUNCE_CYCLES`=1, go directly to `STABLE_HI` instead.
  - `WAIT_HI`: if `sync_q`=0, abort to `STABLE_LO` with `cnt`=0 and no output change. If `cnt`=`DEBOUNCE_CYCLES`-1 and `sync_q`=1, go to `STABLE_HI`, set `clean_out`=1 and `rise_pulse`=1. Otherwise increment `cnt`.
  - `STABLE_HI` and `WAIT_LO` mirror these with the levels inverted and `fall_pulse` in place of `rise_pulse`.
- Counter width is `$clog2(DEBOUNCE_CYCLES+1)`. The counter never wraps; it is cleared on every abort and on every accept.
- Channels are fully independent. Simultaneous transitions on several channels may pulse in the same cycle. `any_change` is then a single 1.
- `clean_out` changes only in the same cycle as its edge pulse. A pulse is never emitted without a level change.

## Timing
- Reset (any cycle, including mid-debounce):
  - All synchroniser flops are cleared to 0.
  - All FSMs go to `STABLE_LO` with `cnt`=0.
  - `clean_out`=0, `rise_pulse`=0, `fall_pulse`=0, `any_change`=0.
  - A debounce in progress is discarded.
- A `raw_in` bit held at 1 through reset is debounced normally after reset release and yields a `rise_pulse`.
- Latency: take the first edge that samples a new `raw_in` level as edge 1. If the level is held, `clean_out` and the pulse update at edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`. Default parameters give 1_000_002 cycles.
- Pulses are registered and last exactly one cycle.
- Glitches:
  - A level shorter than `DEBOUNCE_CYCLES` cycles at `sync_q` produces no output change.
  - A bounce that reverts during a `WAIT` state restarts qualification from zero on the next transition.
- All outputs come directly from flops; there is no combinational path from `raw_in`.

## Structure
- Package `sw_debounce_pkg` holds:
  - the `db_state_t` enum for the four states;
  - the default constants `DB_SYNC_STAGES_DEF`=2 and `DB_CYCLES_DEF`=1_000_000.
- Sub-module `debounce_channel`, instantiated `WIDTH` times via generate, contains:
  - the single-bit synchroniser;
  - the FSM and counter;
  - the `clean`, `rise` and `fall` output flops.
- The top level only instantiates the channels and ORs the pulses to form `any_change`.
- Elaboration-time assertions: `DEBOUNCE_CYCLES`≥1 and `SYNC_STAGES`≥2.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `SYNC_STAGES`=2.
- Clean press: `raw_in` 000→001 before edge 1 and held → `clean_out`=001 and `rise_pulse`=001 after edge 6. `rise_pulse` returns to 000 after edge 7. `any_change` is 1 for that single cycle.
- Bounce reject: `raw_in[1]` toggles 1,0,1,0 with 2-cycle high/low periods, then stays 0 → `clean_out` stays 000 and no pulses occur. A later 1 held for 6 edges → rise accepted.
- Release: channel 0 is stable high, then `raw_in[0]`→0 and held → `clean_out[0]`=0 and `fall_pulse`=001 after the 6th edge. `rise_pulse` stays 000.
- Simultaneous: `raw_in` 000→111 on the same cycle → all three bits rise together. `rise_pulse`=111 for one cycle and `any_change` is a single 1-cycle pulse.
- Reset mid-operation: assert `rst` during `WAIT_HI` at `cnt`=2 → all outputs 000 next cycle. With `raw_in`=001 still held after release → rise occurs at edge 6 counted from the first post-reset edge.
- Boundary: a high level lasting exactly 3 cycles at `sync_q` → no change. Exactly 4 cycles → accepted.
